bicubic_weight_gen: RTL and testbench

Parametrised, pipelined bicubic kernel weight generator: for each accepted fractional phase t it produces all four tap weights W(1+t), W(t), W(1−t), W(2−t) for Keys' kernel with runtime parameter a = −A. It sits between the scaler's phase accumulator and the 4-tap horizontal/vertical MAC stages. It supersedes the per-tap fixed-ratio weight blocks. It adds:
- arbitrary fraction width;
- valid/ready backpressure;
- a sideband tag;
- optional exact unity-sum normalisation.

---
 rtl/bicubic_weight_gen_if.sv | 29 ++
 rtl/bicubic_weight_gen.sv | 257 +++++++++++++++++++++++++
 tb/tb_bicubic_weight_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bicubic_weight_gen_if.sv
// Phase-in / weights-out handshake bundle for bicubic_weight_gen.
// master: phase source plus weight sink; slave: the weight generator.
interface bicubic_weight_gen_if #(
  parameter int FRAC_W = 8,
  parameter int COEF_W = FRAC_W + 2,
  parameter int TAG_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [FRAC_W-1:0]        in_t;
  logic [FRAC_W:0]          in_a;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [COEF_W-1:0] out_w0;
  logic signed [COEF_W-1:0] out_w1;
  logic signed [COEF_W-1:0] out_w2;
  logic signed [COEF_W-1:0] out_w3;
  logic [TAG_W-1:0]         out_tag;

  modport master (
    output in_valid, in_t, in_a, in_tag, out_ready,
    input  in_ready, out_valid, out_w0, out_w1, out_w2, out_w3, out_tag
  );
  modport slave (
    input  in_valid, in_t, in_a, in_tag, out_ready,
    output in_ready, out_valid, out_w0, out_w1, out_w2, out_w3, out_tag
  );
endinterface

// File: rtl/bicubic_weight_gen.sv
// Keys bicubic 4-tap weight generator: 5-stage pipeline, 1 phase/cycle.
// Global stall: every stage holds while out_valid && !out_ready; in_ready mirrors that enable.
module bicubic_weight_gen #(
  parameter int FRAC_W = 8,
  parameter int COEF_W = FRAC_W + 2,
  parameter int TAG_W  = 16,
  parameter bit NORM   = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  bicubic_weight_gen_if.slave bus
);
  localparam int DW = FRAC_W + 2;        // distance reaches 2*ONE at t=0
  localparam int AW = FRAC_W + 1;
  localparam int KW = FRAC_W + 3;
  localparam int SW = 2 * DW;
  localparam int CW = 3 * DW;
  localparam int PW = 4 * FRAC_W + 8;
  localparam int NW = COEF_W + FRAC_W + 4;

  localparam logic [AW-1:0] ONE_A   = AW'(1) << FRAC_W;
  localparam logic [DW-1:0] ONE_D   = DW'(1) << FRAC_W;
  localparam logic [DW-1:0] TWO_D   = DW'(2) << FRAC_W;
  localparam logic [KW-1:0] K_TWO   = KW'(2) << FRAC_W;
  localparam logic [KW-1:0] K_THREE = KW'(3) << FRAC_W;

  localparam logic signed [PW-1:0] UNIT4 = PW'(1) << (4 * FRAC_W);
  localparam logic signed [PW-1:0] FOUR3 = PW'(4) << (3 * FRAC_W);
  localparam logic signed [PW-1:0] HALF3 = PW'(1) << (3 * FRAC_W - 1);
  localparam logic signed [PW-1:0] C5    = PW'(5);
  localparam logic signed [PW-1:0] C8    = PW'(8);
  localparam logic signed [PW-1:0] W_MAX = PW'((1 << (COEF_W - 1)) - 1);
  localparam logic signed [PW-1:0] W_MIN = ~W_MAX;
  localparam logic signed [NW-1:0] N_MAX = NW'((1 << (COEF_W - 1)) - 1);
  localparam logic signed [NW-1:0] N_MIN = ~N_MAX;
  localparam logic signed [NW-1:0] ONE_N = NW'(1) << FRAC_W;

  logic en;

  logic              s1_vld_q, s1_vld_d;
  logic [AW-1:0]     s1_a_q, s1_a_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [DW-1:0]     s1_d_q [4];
  logic [DW-1:0]     s1_d_d [4];

  logic              s2_vld_q, s2_vld_d;
  logic [AW-1:0]     s2_a_q, s2_a_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic [DW-1:0]     s2_d_q [4];
  logic [DW-1:0]     s2_d_d [4];
  logic [SW-1:0]     s2_sq_q [4];
  logic [SW-1:0]     s2_sq_d [4];

  logic              s3_vld_q, s3_vld_d;
  logic [AW-1:0]     s3_a_q, s3_a_d;
  logic [KW-1:0]     s3_k2_q, s3_k2_d;
  logic [KW-1:0]     s3_k3_q, s3_k3_d;
  logic [TAG_W-1:0]  s3_tag_q, s3_tag_d;
  logic [DW-1:0]     s3_d_q [4];
  logic [DW-1:0]     s3_d_d [4];
  logic [SW-1:0]     s3_sq_q [4];
  logic [SW-1:0]     s3_sq_d [4];
  logic [CW-1:0]     s3_cu_q [4];
  logic [CW-1:0]     s3_cu_d [4];

  logic                     s4_vld_q, s4_vld_d;
  logic [TAG_W-1:0]         s4_tag_q, s4_tag_d;
  logic signed [COEF_W-1:0] s4_w_q [4];
  logic signed [COEF_W-1:0] s4_w_d [4];

  logic                     out_vld_q, out_vld_d;
  logic [TAG_W-1:0]         out_tag_q, out_tag_d;
  logic signed [COEF_W-1:0] out_w_q [4];
  logic signed [COEF_W-1:0] out_w_d [4];

  // Exact polynomial at 4*FRAC_W fraction bits, then round half up and saturate.
  function automatic logic signed [COEF_W-1:0] tap_weight(
    input logic          outer,
    input logic [AW-1:0] a,
    input logic [KW-1:0] k2,
    input logic [KW-1:0] k3,
    input logic [DW-1:0] d,
    input logic [SW-1:0] sq,
    input logic [CW-1:0] cu
  );
    logic signed [PW-1:0] pa, pk2, pk3, pd, ps, pc, poly, acc, r;
    pa  = $signed(PW'(a));
    pk2 = $signed(PW'(k2));
    pk3 = $signed(PW'(k3));
    pd  = $signed(PW'(d));
    ps  = $signed(PW'(sq));
    pc  = $signed(PW'(cu));
    if (outer) begin
      poly = FOUR3 - pc + C5 * (ps <<< FRAC_W) - C8 * (pd <<< (2 * FRAC_W));
      acc  = pa * poly;
    end else begin
      acc = pk2 * pc - ((pk3 * ps) <<< FRAC_W) + UNIT4;
    end
    r = (acc + HALF3) >>> (3 * FRAC_W);
    if (r > W_MAX) return W_MAX[COEF_W-1:0];
    if (r < W_MIN) return W_MIN[COEF_W-1:0];
    return r[COEF_W-1:0];
  endfunction

  function automatic logic signed [COEF_W-1:0] sat_n(input logic signed [NW-1:0] v);
    if (v > N_MAX) return N_MAX[COEF_W-1:0];
    if (v < N_MIN) return N_MIN[COEF_W-1:0];
    return v[COEF_W-1:0];
  endfunction

  assign en           = !out_vld_q || bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_tag_d = s1_tag_q;
    s1_d_d   = s1_d_q;
    if (en) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d    = (bus.in_a > ONE_A) ? ONE_A : bus.in_a;
        s1_tag_d  = bus.in_tag;
        s1_d_d[0] = ONE_D + DW'(bus.in_t);
        s1_d_d[1] = DW'(bus.in_t);
        s1_d_d[2] = ONE_D - DW'(bus.in_t);
        s1_d_d[3] = TWO_D - DW'(bus.in_t);
      end
    end
  end

  always_comb begin
    s2_vld_d = s2_vld_q;
    s2_a_d   = s2_a_q;
    s2_tag_d = s2_tag_q;
    s2_d_d   = s2_d_q;
    s2_sq_d  = s2_sq_q;
    if (en) begin
      s2_vld_d = s1_vld_q;
      s2_a_d   = s1_a_q;
      s2_tag_d = s1_tag_q;
      s2_d_d   = s1_d_q;
      for (int i = 0; i < 4; i++) s2_sq_d[i] = SW'(s1_d_q[i]) * SW'(s1_d_q[i]);
    end
  end

  always_comb begin
    s3_vld_d = s3_vld_q;
    s3_a_d   = s3_a_q;
    s3_k2_d  = s3_k2_q;
    s3_k3_d  = s3_k3_q;
    s3_tag_d = s3_tag_q;
    s3_d_d   = s3_d_q;
    s3_sq_d  = s3_sq_q;
    s3_cu_d  = s3_cu_q;
    if (en) begin
      s3_vld_d = s2_vld_q;
      s3_a_d   = s2_a_q;
      s3_k2_d  = K_TWO - KW'(s2_a_q);
      s3_k3_d  = K_THREE - KW'(s2_a_q);
      s3_tag_d = s2_tag_q;
      s3_d_d   = s2_d_q;
      s3_sq_d  = s2_sq_q;
      for (int i = 0; i < 4; i++) s3_cu_d[i] = CW'(s2_sq_q[i]) * CW'(s2_d_q[i]);
    end
  end

  // Taps 0 and 3 sit at distances in [1,2]; taps 1 and 2 in [0,1].
  always_comb begin
    s4_vld_d = s4_vld_q;
    s4_tag_d = s4_tag_q;
    s4_w_d   = s4_w_q;
    if (en) begin
      s4_vld_d = s3_vld_q;
      s4_tag_d = s3_tag_q;
      for (int i = 0; i < 4; i++) begin
        s4_w_d[i] = tap_weight((i == 0) || (i == 3), s3_a_q, s3_k2_q, s3_k3_q,
                               s3_d_q[i], s3_sq_q[i], s3_cu_q[i]);
      end
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_tag_d = out_tag_q;
    out_w_d   = out_w_q;
    if (en) begin
      out_vld_d = s4_vld_q;
      if (s4_vld_q) begin
        out_tag_d = s4_tag_q;
        out_w_d   = s4_w_q;
        if (NORM) begin
          out_w_d[1] = sat_n(ONE_N - NW'(s4_w_q[0]) - NW'(s4_w_q[2]) - NW'(s4_w_q[3]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_tag_q  <= '0;
      s1_d_q    <= '{default: '0};
      s2_vld_q  <= 1'b0;
      s2_a_q    <= '0;
      s2_tag_q  <= '0;
      s2_d_q    <= '{default: '0};
      s2_sq_q   <= '{default: '0};
      s3_vld_q  <= 1'b0;
      s3_a_q    <= '0;
      s3_k2_q   <= '0;
      s3_k3_q   <= '0;
      s3_tag_q  <= '0;
      s3_d_q    <= '{default: '0};
      s3_sq_q   <= '{default: '0};
      s3_cu_q   <= '{default: '0};
      s4_vld_q  <= 1'b0;
      s4_tag_q  <= '0;
      s4_w_q    <= '{default: '0};
      out_vld_q <= 1'b0;
      out_tag_q <= '0;
      out_w_q   <= '{default: '0};
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_tag_q  <= s1_tag_d;
      s1_d_q    <= s1_d_d;
      s2_vld_q  <= s2_vld_d;
      s2_a_q    <= s2_a_d;
      s2_tag_q  <= s2_tag_d;
      s2_d_q    <= s2_d_d;
      s2_sq_q   <= s2_sq_d;
      s3_vld_q  <= s3_vld_d;
      s3_a_q    <= s3_a_d;
      s3_k2_q   <= s3_k2_d;
      s3_k3_q   <= s3_k3_d;
      s3_tag_q  <= s3_tag_d;
      s3_d_q    <= s3_d_d;
      s3_sq_q   <= s3_sq_d;
      s3_cu_q   <= s3_cu_d;
      s4_vld_q  <= s4_vld_d;
      s4_tag_q  <= s4_tag_d;
      s4_w_q    <= s4_w_d;
      out_vld_q <= out_vld_d;
      out_tag_q <= out_tag_d;
      out_w_q   <= out_w_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_w0    = out_w_q[0];
  assign bus.out_w1    = out_w_q[1];
  assign bus.out_w2    = out_w_q[2];
  assign bus.out_w3    = out_w_q[3];
endmodule

// File: tb/tb_bicubic_weight_gen.sv
// Bench for bicubic_weight_gen: known vectors, random stream with backpressure,
// NORM=0 comparison sweep and mid-stream reset, all against a real-valued kernel model.
module tb_bicubic_weight_gen;
  localparam int FW  = 8;
  localparam int AWB = FW + 1;
  localparam int CWI = FW + 2;
  localparam int TW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bicubic_weight_gen_if #(.FRAC_W(FW), .COEF_W(CWI), .TAG_W(TW)) if1 ();
  bicubic_weight_gen_if #(.FRAC_W(FW), .COEF_W(CWI), .TAG_W(TW)) if0 ();

  assign if0.in_valid  = if1.in_valid;
  assign if0.in_t      = if1.in_t;
  assign if0.in_a      = if1.in_a;
  assign if0.in_tag    = if1.in_tag;
  assign if0.out_ready = if1.out_ready;

  bicubic_weight_gen #(.FRAC_W(FW), .COEF_W(CWI), .TAG_W(TW), .NORM(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  bicubic_weight_gen #(.FRAC_W(FW), .COEF_W(CWI), .TAG_W(TW), .NORM(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input bit cond);
    n_checks++;
    if (!cond) begin
      n_fail++;
      $display("FAIL %s: condition false", name);
    end
  endtask

  // Reference model: Keys kernel evaluated in real arithmetic.
  typedef struct { int w[4]; int raw1; int tag; } exp_t;

  function automatic real kernel(input real d, input real a, input bit outer);
    if (outer) return a * (-d * d * d + 5.0 * d * d - 8.0 * d + 4.0);
    return (2.0 - a) * d * d * d - (3.0 - a) * d * d + 1.0;
  endfunction

  function automatic int clamp_w(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic exp_t model(input int t, input int a, input int tag);
    exp_t e;
    real tr, ar;
    real d[4];
    tr = real'(t) / 256.0;
    ar = real'((a > 256) ? 256 : a) / 256.0;
    d[0] = 1.0 + tr; d[1] = tr; d[2] = 1.0 - tr; d[3] = 2.0 - tr;
    for (int i = 0; i < 4; i++)
      e.w[i] = clamp_w(int'($floor(kernel(d[i], ar, (i == 0) || (i == 3)) * 256.0 + 0.5)));
    e.raw1 = e.w[1];
    e.w[1] = clamp_w(256 - e.w[0] - e.w[2] - e.w[3]);
    e.tag  = tag;
    return e;
  endfunction

  exp_t exp_q[$];
  exp_t e_cur;
  bit   held    = 1'b0;
  bit   chk_pm1 = 1'b0;
  int   g[4], g0[4], hw[4];
  int   gtag, htag;

  // Output monitor: ordering, values, hold-stability and NORM=0 relation.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      g[0] = $signed(if1.out_w0); g[1] = $signed(if1.out_w1);
      g[2] = $signed(if1.out_w2); g[3] = $signed(if1.out_w3);
      g0[0] = $signed(if0.out_w0); g0[1] = $signed(if0.out_w1);
      g0[2] = $signed(if0.out_w2); g0[3] = $signed(if0.out_w3);
      gtag = int'(if1.out_tag);
      if (held) begin
        check("hold_valid", int'(if1.out_valid), 1);
        for (int i = 0; i < 4; i++) check($sformatf("hold_w%0d", i), g[i], hw[i]);
        check("hold_tag", gtag, htag);
        held = 1'b0;
      end
      if (if1.out_valid) begin
        if (if1.out_ready) begin
          check_true("out_expected", exp_q.size() > 0);
          if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            for (int i = 0; i < 4; i++) check($sformatf("w%0d", i), g[i], e_cur.w[i]);
            check("tag", gtag, e_cur.tag);
            check("sum", g[0] + g[1] + g[2] + g[3], 256);
            check("n0_valid", int'(if0.out_valid), 1);
            check("n0_w0", g0[0], e_cur.w[0]);
            check("n0_w1", g0[1], e_cur.raw1);
            check("n0_w2", g0[2], e_cur.w[2]);
            check("n0_w3", g0[3], e_cur.w[3]);
            check("n0_tag", int'(if0.out_tag), e_cur.tag);
            if (chk_pm1) check_true("n0_w1_within_1", (g[1] - g0[1] <= 1) && (g0[1] - g[1] <= 1));
          end
        end else begin
          held = 1'b1;
          hw   = g;
          htag = gtag;
        end
      end
      if (if1.in_valid && if1.in_ready) exp_q.push_back(model(int'(if1.in_t), int'(if1.in_a), int'(if1.in_tag)));
    end
  end

  task automatic send(input int t, input int a, input int tag);
    int n;
    bit acc;
    if1.in_valid = 1'b1;
    if1.in_t     = FW'(t);
    if1.in_a     = AWB'(a);
    if1.in_tag   = TW'(tag);
    n = 0;
    do begin
      @(negedge clk);
      acc = if1.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if1.in_valid = 1'b0;
    check_true("send_accepted", acc);
  endtask

  // Edge count from the accepting edge (counted as 1) to out_valid.
  task automatic wait_out(output int n);
    n = 1;
    while (!if1.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  typedef struct { int t; int a; int e[4]; } vec_t;
  vec_t vecs[5];

  task automatic set_vec(input int k, input int t, input int a,
                         input int e0, input int e1, input int e2, input int e3);
    vecs[k].t = t; vecs[k].a = a;
    vecs[k].e[0] = e0; vecs[k].e[1] = e1; vecs[k].e[2] = e2; vecs[k].e[3] = e3;
  endtask

  task automatic check_outs(input string pfx, input int e0, input int e1, input int e2, input int e3);
    check({pfx, "_w0"}, int'($signed(if1.out_w0)), e0);
    check({pfx, "_w1"}, int'($signed(if1.out_w1)), e1);
    check({pfx, "_w2"}, int'($signed(if1.out_w2)), e2);
    check({pfx, "_w3"}, int'($signed(if1.out_w3)), e3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nv, cyc;
    bit done;
    if1.in_valid  = 1'b0;
    if1.in_t      = '0;
    if1.in_a      = '0;
    if1.in_tag    = '0;
    if1.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_out_valid", int'(if1.out_valid), 0);
    check_outs("rst", 0, 0, 0, 0);
    check("rst_out_tag", int'(if1.out_tag), 0);
    check("rst_in_ready", int'(if1.in_ready), 1);
    check("rst_n0_valid", int'(if0.out_valid), 0);

    set_vec(0, 0,   128, 0,   256, 0,   0);
    set_vec(1, 128, 128, -16, 144, 144, -16);
    set_vec(2, 64,  128, -18, 222, 58,  -6);
    set_vec(3, 128, 256, -32, 160, 160, -32);
    set_vec(4, 128, 400, -32, 160, 160, -32);
    if1.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(vecs[k].t, vecs[k].a, 16'hA000 + k);
      wait_out(lat);
      check($sformatf("vec%0d_latency", k), lat, 5);
      check_outs($sformatf("vec%0d", k), vecs[k].e[0], vecs[k].e[1], vecs[k].e[2], vecs[k].e[3]);
      check($sformatf("vec%0d_tag", k), int'(if1.out_tag), 16'hA000 + k);
      @(posedge clk);
      #1;
    end

    // Random stream with random downstream backpressure.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 64; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send($urandom_range(0, 255), $urandom_range(0, 511), $urandom_range(0, 65535));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          if1.out_ready = ($urandom_range(0, 1) == 1);
          @(posedge clk);
          #1;
        end
      end
    join
    if1.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("random_drain", exp_q.size(), 0);

    // Full t sweep at A=192, back to back, against the NORM=0 instance.
    chk_pm1 = 1'b1;
    for (int t = 0; t < 256; t++) send(t, 192, t);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("sweep_drain", exp_q.size(), 0);
    chk_pm1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three transactions in flight.
    for (int k = 0; k < 3; k++) send(10 + 50 * k, 128, 16'h0055 + k);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", int'(if1.in_ready), 1);
    check("mid_rst_out_valid", int'(if1.out_valid), 0);
    nv = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (if1.out_valid) nv++;
    end
    check("mid_rst_no_stale", nv, 0);
    send(64, 128, 16'h0077);
    wait_out(lat);
    check("post_rst_latency", lat, 5);
    check_outs("post_rst", -18, 222, 58, -6);
    check("post_rst_tag", int'(if1.out_tag), 16'h0077);
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
